// File: rtl/data_sram_arb_if.sv
// Bundle of the IF port, the data port and the shared SRAM port seen by data_sram_arb.
// The arbiter uses the slave modport; the requesters/SRAM environment uses master.
interface data_sram_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        stall_req;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_wen, d_addr, d_wdata,
    input  sram_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    output stall_req
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_wen, d_addr, d_wdata,
    output sram_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    input  stall_req
  );
endinterface

// File: rtl/data_sram_arb.sv
// Arbiter sharing one single-cycle-latency SRAM port between instruction fetch and data access.
// Default: data priority with an IF starvation limit; define DATA_SRAM_ARB_RR_EN for round-robin.
module data_sram_arb #(
  parameter int unsigned MAX_DATA_RUN = 3
) (
  input logic            clk,
  input logic            rst,
  data_sram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e owner_q;
  owner_e owner_d;
  logic   gnt_if;
  logic   gnt_d;
  logic   conflict;

  assign conflict = bus.if_req & bus.d_req;

`ifdef DATA_SRAM_ARB_RR_EN
  // last_if_q=1 means IF won the most recent grant; reset value lets data win the first conflict.
  logic last_if_q;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      if (conflict) begin
        gnt_if = ~last_if_q;
        gnt_d  = last_if_q;
      end else begin
        gnt_if = bus.if_req;
        gnt_d  = bus.d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_if_q <= 1'b1;
    end else if (gnt_if || gnt_d) begin
      last_if_q <= gnt_if;
    end
  end
`else
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

  // Consecutive data grants taken while IF was waiting.
  logic [3:0] run_q;
  logic       if_turn;

  assign if_turn = (run_q == RUN_LIMIT);

  // NOTE: every output of a combinational block gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      if (conflict) begin
        gnt_if = if_turn;
        gnt_d  = ~if_turn;
      end else begin
        gnt_if = bus.if_req;
        gnt_d  = bus.d_req;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !bus.if_req || gnt_if) begin
      run_q <= 4'd0;
    end else if (gnt_d && (run_q != 4'hF)) begin
      run_q <= run_q + 4'd1;
    end
  end
`endif

  // Read-owner FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Read-owner FSM: next state; only reads produce a response next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_if) begin
      owner_d = OWN_IF;
    end else if (gnt_d && (bus.d_wen == 4'b0000)) begin
      owner_d = OWN_DATA;
    end
  end

  // Read-owner FSM and grant outputs; rst kills a response already in flight.
  always_comb begin
    bus.if_gnt     = gnt_if;
    bus.d_gnt      = gnt_d;
    bus.if_rvalid  = (owner_q == OWN_IF)   && !rst;
    bus.d_rvalid   = (owner_q == OWN_DATA) && !rst;
    bus.sram_en    = gnt_if | gnt_d;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    if (gnt_d) begin
      bus.sram_wen   = bus.d_wen;
      bus.sram_addr  = bus.d_addr;
      bus.sram_wdata = bus.d_wdata;
    end else if (gnt_if) begin
      bus.sram_addr  = bus.if_addr;
    end
    bus.stall_req = !rst && ((bus.if_req && !gnt_if) || (bus.d_req && !gnt_d));
  end

  assign bus.if_rdata = bus.sram_rdata;
  assign bus.d_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_data_sram_arb.sv
// Randomized scoreboard bench for data_sram_arb against a request-level reference model.
// Define DATA_SRAM_ARB_RR_EN for both RTL and bench to exercise the round-robin build.
module tb_data_sram_arb;

  localparam int MAX_RUN = 3;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_sram_arb_if bus ();

  data_sram_arb #(.MAX_DATA_RUN(MAX_RUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int      n_vec = 0;
  int      n_err = 0;
  int      cur_cyc = 0;
  bit      cur_rst = 1'b1;
  bit      mon_on = 1'b0;
  rd_exp_t q_if[$];
  rd_exp_t q_d[$];
  logic [7:0] gseq;

  // Reference model state: data grants since IF was last served while waiting, last winner.
  int          run = 0;
  bit          last_was_d = 1'b0;
  logic [31:0] model_mem [256];

  // SRAM environment: one-cycle read latency, byte-enabled writes.
  logic [31:0] sram_mem [256];
  initial for (int i = 0; i < 256; i++) sram_mem[i] <= seed(i);

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wen == 4'b0000) begin
        bus.sram_rdata <= sram_mem[bus.sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wen[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] seed(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cur_cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus: drive, predict, compare grant-cycle outputs, advance the model.
  task automatic cycle(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dwd);
    bit e_if;
    bit e_d;
    @(posedge clk);
    #1;
    rst         = r;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_wen   = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    cur_cyc++;
    cur_rst = r;

    e_if = 1'b0;
    e_d  = 1'b0;
    if (!r) begin
      if (ir && dr) begin
`ifdef DATA_SRAM_ARB_RR_EN
        e_d = !last_was_d;
`else
        e_d = (run != MAX_RUN);
`endif
        e_if = !e_d;
      end else begin
        e_if = ir;
        e_d  = dr;
      end
    end

    #3;
    check("if_gnt", 32'(bus.if_gnt), 32'(e_if));
    check("d_gnt", 32'(bus.d_gnt), 32'(e_d));
    check("sram_en", 32'(bus.sram_en), 32'(e_if | e_d));
    check("sram_wen", 32'(bus.sram_wen), e_d ? 32'(dw) : 32'h0);
    check("stall_req", 32'(bus.stall_req), r ? 32'h0 : 32'((ir && !e_if) || (dr && !e_d)));
    if (e_if || e_d) begin
      check("sram_addr", bus.sram_addr, e_d ? da : ia);
      check("sram_wdata", bus.sram_wdata, e_d ? dwd : 32'h0);
    end
    gseq = {gseq[6:0], bus.d_gnt};

    if (r) begin
      run        = 0;
      last_was_d = 1'b0;
    end else begin
      if (!ir || e_if) run = 0;
      else if (e_d && run < 15) run++;
      if (e_if || e_d) last_was_d = e_d;
      if (e_if) q_if.push_back('{cyc: cur_cyc + 1, data: model_mem[ia[9:2]]});
      if (e_d) begin
        if (dw == 4'b0000) q_d.push_back('{cyc: cur_cyc + 1, data: model_mem[da[9:2]]});
        else for (int b = 0; b < 4; b++)
          if (dw[b]) model_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
      end
    end
  endtask

  // Monitor: every cycle, compare read responses against the scoreboard queues.
  initial begin : monitor
    bit          ev;
    logic [31:0] ed;
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        ev = 1'b0;
        ed = 32'h0;
        if (q_if.size() > 0 && q_if[0].cyc == cur_cyc) begin
          ed = q_if[0].data;
          ev = !cur_rst;
          void'(q_if.pop_front());
        end
        check("if_rvalid", 32'(bus.if_rvalid), 32'(ev));
        if (ev) check("if_rdata", bus.if_rdata, ed);

        ev = 1'b0;
        ed = 32'h0;
        if (q_d.size() > 0 && q_d[0].cyc == cur_cyc) begin
          ed = q_d[0].data;
          ev = !cur_rst;
          void'(q_d.pop_front());
        end
        check("d_rvalid", 32'(bus.d_rvalid), 32'(ev));
        if (ev) check("d_rdata", bus.d_rdata, ed);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = seed(i);
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_wen   = 4'h0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    gseq        = 8'h0;
    mon_on      = 1'b1;

    // Reset state, with requests pending that must be ignored.
    cycle(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    cycle(1, 1, 32'h4, 1, 4'h0, 32'h8, 32'h0);
    cycle(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // IF-only read, then data-only partial write.
    cycle(0, 1, 32'h0000_0100, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 0, 32'h0, 1, 4'b0011, 32'h80, 32'h1234_ABCD);
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h80, 32'h0);

    // Both requesting for 8 cycles.
    for (int i = 0; i < 8; i++)
      cycle(0, 1, 32'h200 + 32'(4 * i), 1, 4'h0, 32'h40 + 32'(4 * i), 32'h0);
`ifdef DATA_SRAM_ARB_RR_EN
    check("gnt_seq_8", 32'(gseq), 32'b0101_0101);
`else
    check("gnt_seq_8", 32'(gseq), 32'b1110_1110);
`endif
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // Both requesting for 4 cycles straight out of reset.
    cycle(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 32'h300 + 32'(4 * i), 1, 4'h0, 32'h20 + 32'(4 * i), 32'h0);
`ifdef DATA_SRAM_ARB_RR_EN
    check("gnt_seq_4", 32'(gseq[3:0]), 32'b1010);
`else
    check("gnt_seq_4", 32'(gseq[3:0]), 32'b1110);
`endif

    // Data read, reset the next cycle, then data request right after reset.
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h10, 32'h0);
    cycle(1, 0, 32'h0, 1, 4'h0, 32'h14, 32'h0);
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h18, 32'h0);
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // Back-to-back data reads.
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
    cycle(0, 0, 32'h0, 1, 4'h0, 32'h8, 32'h0);
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 2) != 0, $urandom & 32'h3FC,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            $urandom & 32'h3FC, $urandom);
    end

    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    check("if_queue_drained", 32'(q_if.size()), 32'h0);
    check("d_queue_drained", 32'(q_d.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_arb.md
DATA_SRAM_ARB -- requirements
Module: data_sram_arb

Interface
REQ-001 SHALL have parameter: MAX_DATA_RUN, default 3, max consecutive data grants while an IF request waits (range 1..15).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: if_req  input  1; if_addr  input  32; instruction-fetch read request (read-only).
REQ-005 SHALL have ports: if_gnt  output  1; if_rvalid  output  1; if_rdata  output  32; IF grant, read-data valid, read data.
REQ-006 SHALL have ports: d_req  input  1; d_wen  input  4; d_addr  input  32; d_wdata  input  32; data request, byte write enables (0000 = read).
REQ-007 SHALL have ports: d_gnt  output  1; d_rvalid  output  1; d_rdata  output  32; data grant, load-data valid, load data.
REQ-008 SHALL have ports: sram_en  output  1; sram_wen  output  4; sram_addr  output  32; sram_wdata  output  32; sram_rdata  input  32; single shared SRAM port.
REQ-009 SHALL have port: stall_req  output  1  request to pipeline stall controller.

Function
REQ-010 SHALL grant at most one requester per cycle; grants are combinational from current req and registered state.
REQ-011 SHALL drive sram_en=1 and forward the granted requester's addr/wen/wdata (IF: wen=0000, wdata=0) in the grant cycle; otherwise sram_en=0, sram_wen=0000.
REQ-012 SHALL assume SRAM read latency of exactly one cycle: xx_rvalid asserted in the cycle after a read grant, xx_rdata=sram_rdata in that cycle.
REQ-013 SHALL NOT assert d_rvalid for a write grant (d_wen!=0000).
REQ-014 SHALL hold a registered read-owner state: NONE, IF, DATA; set on read grant, cleared to NONE next cycle unless a new read grant occurs.
REQ-015 SHALL drive if_rdata and d_rdata to sram_rdata continuously; only rvalid qualifies them.
REQ-016 SHALL use data priority: d_req wins over if_req, except per REQ-017.
REQ-017 SHALL count consecutive data grants with if_req pending (4-bit, saturating); when count==MAX_DATA_RUN and if_req=1, grant IF and clear counter.
REQ-018 SHALL clear the counter on any IF grant or any cycle with if_req=0.
REQ-019 SHALL assert stall_req = (if_req & ~if_gnt) | (d_req & ~d_gnt).
REQ-020 SHALL, when only one requester is active, grant it every cycle (back-to-back, full throughput).
REQ-021 SHALL allow a new grant in the same cycle as a previous read's rvalid (pipelined; no bubble).

Reset
REQ-022 SHALL, while rst=1, force read-owner=NONE, counter=0, if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, sram_en=0, sram_wen=0000, stall_req=0.
REQ-023 SHALL, on rst asserted one cycle after a read grant, suppress that read's rvalid.
REQ-024 SHALL accept requests in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with macro DATA_SRAM_ARB_RR_EN defined, replace REQ-016/017 with round-robin: on conflict grant the requester not granted last (registered last-grant bit, reset to IF so data wins first conflict); counter unused.
REQ-026 SHALL, without DATA_SRAM_ARB_RR_EN, implement data priority with starvation limit per REQ-016/017.

Verification
REQ-027 SHALL cover: if_req only, if_addr=0x00000100 -> if_gnt=1 same cycle, sram_addr=0x100, if_rvalid=1 next cycle with if_rdata=sram_rdata.
REQ-028 SHALL cover: d_req only, d_wen=0011, d_addr=0x80, d_wdata=0x1234ABCD -> d_gnt=1, sram_wen=0011, sram_wdata=0x1234ABCD, no d_rvalid next cycle.
REQ-029 SHALL cover: if_req and d_req held high 8 cycles, MAX_DATA_RUN=3 -> grant sequence D,D,D,I,D,D,D,I; stall_req=1 every cycle.
REQ-030 SHALL cover: read grant to data, rst=1 next cycle -> d_rvalid=0, sram_en=0; after rst drops with d_req=1 -> d_gnt=1 immediately.
REQ-031 SHALL cover: DATA_SRAM_ARB_RR_EN defined, both requesting 4 cycles from reset -> grants D,I,D,I.
REQ-032 SHALL cover: back-to-back data reads addr 0x0,0x4,0x8 -> d_rvalid=1 on three consecutive cycles, each carrying sram_rdata of that cycle.
